// File: rtl/vit_tbck.sv
// Survivor-path memory and traceback for the Viterbi decoder: stores one ACS
// decision vector per trellis step, then walks back from best_st and replays bits oldest-first.
module vit_tbck #(
  parameter int ST_W  = 2,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_mem,
  input  logic                 en_tbck,
  input  logic [2**ST_W-1:0]   dec_in,
  input  logic [ST_W-1:0]      best_st,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 done,
  output logic                 ovf
);

  localparam int NS = 2**ST_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic [2:0] {IDLE, FILL, TRACE, OUT, DONE} state_t;

  state_t          state, state_nxt;
  logic            wr_en;
  logic [PW-1:0]   wr_ptr, rd_ptr, out_ptr, n_bits;
  logic [ST_W-1:0] cur_st;
  logic [NS-1:0]   mem  [DEPTH];
  logic            bits [DEPTH];

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (en_tbck) begin
          state_nxt = DONE;
        end else if (en_mem) begin
          wr_en     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        // Traceback start takes priority: the control FSM keeps en_mem high here
        if (en_tbck) begin
          state_nxt = TRACE;
        end else if (en_mem && (wr_ptr < DEPTH_P)) begin
          wr_en = 1'b1;
        end
      end
      TRACE: begin
        if (rd_ptr == '0) state_nxt = OUT;
      end
      OUT: begin
        if (out_ptr == n_bits - ONE_P) state_nxt = DONE;
      end
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= dec_in;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == TRACE) bits[rd_ptr[AW-1:0]] <= cur_st[ST_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_ptr    <= '0;
      n_bits     <= '0;
      cur_st     <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!en_tbck && en_mem) wr_ptr <= ONE_P;
        end
        FILL: begin
          if (en_tbck) begin
            cur_st <= best_st;
            rd_ptr <= wr_ptr - ONE_P;
            n_bits <= wr_ptr;
          end else if (en_mem) begin
            if (wr_ptr < DEPTH_P) wr_ptr <= wr_ptr + ONE_P;
            else                  ovf    <= 1'b1;
          end
        end
        TRACE: begin
          // Predecessor shifts the stored survivor choice in at the LSB
          cur_st <= {cur_st[ST_W-2:0], mem[rd_ptr[AW-1:0]][cur_st]};
          if (rd_ptr == '0) out_ptr <= '0;
          else              rd_ptr  <= rd_ptr - ONE_P;
        end
        OUT: begin
          dout       <= bits[out_ptr[AW-1:0]];
          dout_valid <= 1'b1;
          out_ptr    <= out_ptr + ONE_P;
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vit_tbck.sv
// Directed testbench for vit_tbck: frames of hand-computed decision vectors,
// checking decoded bit order, output timing, overflow and reset behaviour.
module tb_vit_tbck;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_mem = 1'b0;
  logic       en_tbck = 1'b0;
  logic [3:0] dec_in = '0;
  logic [1:0] best_st = '0;
  logic       dout, dout_valid, done, ovf;

  int tests = 0;
  int fails = 0;

  vit_tbck #(.ST_W(2), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en_mem(en_mem), .en_tbck(en_tbck),
    .dec_in(dec_in), .best_st(best_st),
    .dout(dout), .dout_valid(dout_valid), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic m, input logic t, input logic [3:0] d, input logic [1:0] b);
    en_mem  = m;
    en_tbck = t;
    dec_in  = d;
    best_st = b;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 2'b00);
    rst = 1'b0;
  endtask

  task automatic writeN(input int n, input logic [3:0] d);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, d, 2'b00);
  endtask

  // en_tbck at edge E, then collect bits and timing until done appears
  task automatic traceAndCheck(input string tag, input logic [3:0] d, input logic [1:0] b,
                               input int exp_n, input logic [7:0] exp_bits);
    int cnt = 0;
    int first_v = -1;
    int done_e = -1;
    logic [7:0] got = '0;
    applyStimulus(1'b1, 1'b1, d, b);
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1'b1, 1'b0, d, b);
      if (dout_valid) begin
        if (first_v < 0) first_v = k;
        if (cnt < 8) got[cnt] = dout;
        cnt++;
      end
      if (done) begin
        done_e = k;
        break;
      end
    end
    checkOutput({tag, "_count"}, cnt, exp_n);
    checkOutput({tag, "_bits"}, {24'd0, got}, {24'd0, exp_bits});
    checkOutput({tag, "_done_edge"}, done_e, 2 * exp_n + 1);
    if (exp_n > 0) checkOutput({tag, "_first_edge"}, first_v, exp_n + 1);
    applyStimulus(1'b1, 1'b1, d, b);
    checkOutput({tag, "_done_hold"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_valid_low"}, {31'd0, dout_valid}, 32'd0);
    if (exp_n > 0) checkOutput({tag, "_dout_hold"}, {31'd0, dout}, {31'd0, exp_bits[exp_n-1]});
  endtask

  initial begin
    int nv;
    resetDut();
    checkOutput("rst_dout", {31'd0, dout}, 32'd0);
    checkOutput("rst_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);

    writeN(8, 4'b0000);
    traceAndCheck("zeros_b10", 4'b0000, 2'b10, 8, 8'b1000_0000);
    checkOutput("zeros_ovf", {31'd0, ovf}, 32'd0);

    resetDut();
    writeN(8, 4'b1111);
    traceAndCheck("ones_b11", 4'b1111, 2'b11, 8, 8'b1111_1111);

    resetDut();
    writeN(8, 4'b1111);
    traceAndCheck("ones_b00", 4'b1111, 2'b00, 8, 8'b0011_1111);

    resetDut();
    writeN(8, 4'b0000);
    checkOutput("ovf_after8", {31'd0, ovf}, 32'd0);
    writeN(1, 4'b1111);
    checkOutput("ovf_after9", {31'd0, ovf}, 32'd1);
    writeN(1, 4'b1111);
    traceAndCheck("ovf_frame", 4'b0000, 2'b10, 8, 8'b1000_0000);
    checkOutput("ovf_sticky", {31'd0, ovf}, 32'd1);

    resetDut();
    writeN(3, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b1111, 2'b00);
    applyStimulus(1'b0, 1'b0, 4'b1111, 2'b00);
    traceAndCheck("gap3", 4'b0000, 2'b10, 3, 8'b0000_0100);

    resetDut();
    writeN(4, 4'b0000);
    traceAndCheck("tbck_w5", 4'b1111, 2'b10, 4, 8'b0000_1000);

    resetDut();
    traceAndCheck("idle_tbck", 4'b1111, 2'b11, 0, 8'b0000_0000);

    // Overflowed all-ones frame, reset after three output bits
    resetDut();
    writeN(10, 4'b1111);
    checkOutput("mid_ovf_set", {31'd0, ovf}, 32'd1);
    applyStimulus(1'b1, 1'b1, 4'b1111, 2'b11);
    nv = 0;
    for (int k = 0; k < 40 && nv < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 4'b1111, 2'b11);
      if (dout_valid) nv++;
    end
    checkOutput("mid_bits_seen", nv, 3);
    checkOutput("mid_dout_pre", {31'd0, dout}, 32'd1);
    resetDut();
    checkOutput("mid_rst_dout", {31'd0, dout}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
    checkOutput("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    writeN(8, 4'b1111);
    traceAndCheck("post_rst", 4'b1111, 2'b00, 8, 8'b0011_1111);
    checkOutput("post_rst_ovf", {31'd0, ovf}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
